// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: per-bit 2-flop synchroniser, debounce filter, edge strobes.
// Ports: aclk/areset (async, active-high); pad_in raw lines; debounce_limit
//   stable cycles needed; gpio_in filtered level; rise/fall 1-cycle strobes.
// Build option: define GPIO_IN_EDGE_EN to build the rise/fall strobe flops;
//   otherwise rise/fall are tied low.
module gpio_in_debounce #(
  parameter int P_WIDTH     = 32,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [P_WIDTH-1:0]     pad_in,
  input  logic [P_CNT_WIDTH-1:0] debounce_limit,
  output logic [P_WIDTH-1:0]     gpio_in,
  output logic [P_WIDTH-1:0]     rise,
  output logic [P_WIDTH-1:0]     fall
);

  localparam logic [P_CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE  = 1;

  logic [P_WIDTH-1:0]     sync1_q;
  logic [P_WIDTH-1:0]     sync2_q;
  logic [P_WIDTH-1:0]     stable_q;
  logic [P_WIDTH-1:0]     stable_d;
  logic [P_WIDTH-1:0]     accept;
  logic [P_CNT_WIDTH-1:0] cnt_q [P_WIDTH];
  logic [P_CNT_WIDTH-1:0] cnt_d [P_WIDTH];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
    end
  end

  // cnt counts mismatch cycles already seen; a change is taken once the
  // count reaches the limit, so cnt never exceeds debounce_limit.
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < P_WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] >= debounce_limit) begin
        accept[i]   = 1'b1;
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stable_q <= '1;
      for (int i = 0; i < P_WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < P_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gpio_in = stable_q;

`ifdef GPIO_IN_EDGE_EN
  logic [P_WIDTH-1:0] rise_q;
  logic [P_WIDTH-1:0] rise_d;
  logic [P_WIDTH-1:0] fall_q;
  logic [P_WIDTH-1:0] fall_d;

  // Strobes align with the cycle gpio_in takes its new value.
  always_comb begin
    rise_d = accept & sync2_q;
    fall_d = accept & ~sync2_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
